// File: rtl/pwm_sample_adapter.sv
// Purpose: pops CHANNELS FIFO words per sample period, reduces each to OUT_WIDTH and publishes a double-buffered PWM frame.
// Latency: a word reaches sample_out exactly one sample period after the tick that started its fetch.
// Backpressure: none upstream; an empty FIFO at a tick is an underrun (mid-scale fill or hold, counted).
module pwm_sample_adapter #(
   parameter int IN_WIDTH   = 16,
   parameter int OUT_WIDTH  = 8,
   parameter int CHANNELS   = 1,
   parameter int SAMPLE_DIV = 2500,
   parameter int DIV_WIDTH  = 12
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          enable,
   input  logic [1:0]                    mode,
   input  logic                          underrun_mute,
   input  logic [IN_WIDTH-1:0]           fifo_data,
   input  logic                          fifo_empty_n,
   output logic                          fifo_rd,
   output logic [CHANNELS*OUT_WIDTH-1:0] sample_out,
   output logic                          sample_valid,
   output logic                          underrun,
   output logic [15:0]                   underrun_count
);

   localparam int S    = IN_WIDTH - OUT_WIDTH;
   localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam bit ODD_OK = (IN_WIDTH == 2 * OUT_WIDTH);
   localparam logic [OUT_WIDTH-1:0] MID      = OUT_WIDTH'(1) << (OUT_WIDTH - 1);
   localparam logic [CH_W-1:0]      LAST_CH  = CH_W'(CHANNELS - 1);
   localparam logic [DIV_WIDTH-1:0] LAST_CNT = DIV_WIDTH'(SAMPLE_DIV - 1);
   localparam logic [IN_WIDTH:0]    HALF     = (IN_WIDTH + 1)'(1) << (S - 1);

   typedef enum logic [2:0] {S_IDLE, S_WAIT, S_FETCH, S_GAP, S_FULL} state_t;

   state_t                        state_q, state_d;
   logic [CH_W-1:0]               ch_q, ch_d;
   logic [DIV_WIDTH-1:0]          cnt_q, cnt_d;
   logic                          first_q, first_d;
   logic [CHANNELS*OUT_WIDTH-1:0] stage_q, stage_d;
   logic [CHANNELS*OUT_WIDTH-1:0] sample_out_q, sample_out_d;
   logic                          sample_valid_q, sample_valid_d;
   logic                          underrun_q, underrun_d;
   logic [15:0]                   ucnt_q, ucnt_d;

   logic                          tick;
   logic [OUT_WIDTH-1:0]          conv;
   logic [OUT_WIDTH-1:0]          odd_pick;
   logic [2*OUT_WIDTH-1:0]        wide;
   logic [IN_WIDTH:0]             rounded;
   logic                          unused_bits;

   // A period boundary only exists while running; the counter is forced to 0 when idle.
   assign tick = enable && (cnt_q == LAST_CNT);

   // Reduce the FIFO head word according to the currently selected mode.
   always_comb begin
      wide    = (2 * OUT_WIDTH)'(fifo_data);
      rounded = {1'b0, fifo_data} + HALF;
      odd_pick = '0;
      for (int k = 0; k < OUT_WIDTH; k++) begin
         odd_pick[k] = wide[2*k+1];
      end
      case (mode)
         2'd0:    conv = ODD_OK ? odd_pick : fifo_data[IN_WIDTH-1:S];
         2'd2:    conv = rounded[IN_WIDTH] ? '1 : rounded[IN_WIDTH-1:S];
         default: conv = fifo_data[IN_WIDTH-1:S];
      endcase
   end

   // Bits that only feed the odd-bit pick or sit below the rounding point.
   assign unused_bits = ^{wide, rounded[S-1:0]};

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         ch_q    <= '0;
      end else begin
         state_q <= state_d;
         ch_q    <= ch_d;
      end
   end

   // Next state: disable wins, then the tick restarts fetching from channel 0.
   always_comb begin
      state_d = state_q;
      ch_d    = ch_q;
      if (!enable) begin
         state_d = S_IDLE;
         ch_d    = '0;
      end else if (tick) begin
         state_d = S_FETCH;
         ch_d    = '0;
      end else begin
         case (state_q)
            S_IDLE:  state_d = S_WAIT;
            S_WAIT:  state_d = S_WAIT;
            S_FETCH: begin
               if (fifo_empty_n) begin
                  if (ch_q == LAST_CH) begin
                     state_d = S_FULL;
                  end else begin
                     ch_d    = ch_q + 1'b1;
                     state_d = S_GAP;
                  end
               end
            end
            S_GAP:   state_d = S_FETCH;
            S_FULL:  state_d = S_FULL;
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Outputs and datapath next values: pop/capture, counter, publish or underrun at the tick.
   always_comb begin
      // No pop on the tick cycle: the fetch restarts next cycle, keeping pops non-adjacent.
      fifo_rd        = (state_q == S_FETCH) && fifo_empty_n && !tick;
      cnt_d          = enable ? (tick ? '0 : cnt_q + 1'b1) : '0;
      first_d        = first_q;
      stage_d        = stage_q;
      sample_out_d   = sample_out_q;
      sample_valid_d = 1'b0;
      underrun_d     = 1'b0;
      ucnt_d         = ucnt_q;
      if (fifo_rd) begin
         stage_d[ch_q*OUT_WIDTH +: OUT_WIDTH] = conv;
      end
      if (!enable) begin
         first_d = 1'b1;
      end else if (tick) begin
         first_d = 1'b0;
         if (!first_q) begin
            sample_valid_d = 1'b1;
            if (state_q == S_FULL) begin
               sample_out_d = stage_q;
            end else begin
               underrun_d = 1'b1;
               if (underrun_mute) begin
                  sample_out_d = {CHANNELS{MID}};
               end
               if (ucnt_q != 16'hFFFF) begin
                  ucnt_d = ucnt_q + 16'd1;
               end
            end
         end
      end
   end

   // Datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q          <= '0;
         first_q        <= 1'b1;
         stage_q        <= '0;
         sample_out_q   <= {CHANNELS{MID}};
         sample_valid_q <= 1'b0;
         underrun_q     <= 1'b0;
         ucnt_q         <= '0;
      end else begin
         cnt_q          <= cnt_d;
         first_q        <= first_d;
         stage_q        <= stage_d;
         sample_out_q   <= sample_out_d;
         sample_valid_q <= sample_valid_d;
         underrun_q     <= underrun_d;
         ucnt_q         <= ucnt_d;
      end
   end

   assign sample_out     = sample_out_q;
   assign sample_valid   = sample_valid_q;
   assign underrun       = underrun_q;
   assign underrun_count = ucnt_q;

endmodule

// File: tb/tb_pwm_sample_adapter.sv
// Purpose: drives a 1-channel and a 2-channel adapter from model FIFOs and scoreboards every published frame.
// Latency: expected frames are queued one period before the DUT publishes them.
// Backpressure: FIFO words are offered only at period boundaries so the model can reason per period.
module tb_pwm_sample_adapter;
   localparam int DIV = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic [1:0]  mode;
   logic        underrun_mute;
   logic [15:0] fd1 = '0, fd2 = '0;
   logic        fe1 = 1'b0, fe2 = 1'b0;
   logic        rd1, rd2;
   logic [7:0]  so1;
   logic [15:0] so2;
   logic        sv1, sv2, ur1, ur2;
   logic [15:0] uc1, uc2;

   always #5 clk = ~clk;

   pwm_sample_adapter #(.IN_WIDTH(16), .OUT_WIDTH(8), .CHANNELS(1), .SAMPLE_DIV(DIV), .DIV_WIDTH(4)) u_dut1 (
      .clk(clk), .rst(rst), .enable(enable), .mode(mode), .underrun_mute(underrun_mute),
      .fifo_data(fd1), .fifo_empty_n(fe1), .fifo_rd(rd1), .sample_out(so1),
      .sample_valid(sv1), .underrun(ur1), .underrun_count(uc1));

   pwm_sample_adapter #(.IN_WIDTH(16), .OUT_WIDTH(8), .CHANNELS(2), .SAMPLE_DIV(DIV), .DIV_WIDTH(4)) u_dut2 (
      .clk(clk), .rst(rst), .enable(enable), .mode(mode), .underrun_mute(underrun_mute),
      .fifo_data(fd2), .fifo_empty_n(fe2), .fifo_rd(rd2), .sample_out(so2),
      .sample_valid(sv2), .underrun(ur2), .underrun_count(uc2));

   typedef struct packed {
      logic [15:0] out;
      logic        ur;
      logic [15:0] cnt;
   } exp_t;

   exp_t        exp1[$], exp2[$];
   logic [15:0] fq1[$], fq2[$], pend1[$], pend2[$];
   logic [15:0] rq1[$], rq2[$];
   int          errors = 0, checks = 0;
   int          pops1 = 0, pops2 = 0, cons1 = 0, cons2 = 0;

   // model state per DUT: pending result of the current period, last published frame, underrun count
   bit          pv1 = 0, pv2 = 0, pfull1 = 0, pfull2 = 0;
   logic [15:0] pframe1 = '0, pframe2 = '0;
   logic [15:0] last1 = 16'h0080, last2 = 16'h8080;
   logic [15:0] ucount1 = '0, ucount2 = '0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, required %h", nm, act, req);
      end
   endtask

   function automatic logic [7:0] conv(input logic [15:0] w, input logic [1:0] m);
      int v;
      logic [7:0] r;
      r = '0;
      case (m)
         2'd0: for (int k = 0; k < 8; k++) r[k] = w[2*k+1];
         2'd2: begin
            v = (int'(w) + 128) / 256;
            r = (v > 255) ? 8'hFF : 8'(v);
         end
         default: r = 8'(int'(w) / 256);
      endcase
      return r;
   endfunction

   // show-ahead FIFO models: pop on fifo_rd, then admit words offered since the last edge
   always @(posedge clk) begin
      logic [15:0] t;
      if (rd1) begin
         if (fq1.size() == 0) begin
            checks++; errors++;
            $display("FAIL pop_empty1: fifo_rd=1, required 0 with FIFO empty");
         end else begin
            t = fq1.pop_front(); pops1++;
         end
      end
      if (rd2) begin
         if (fq2.size() == 0) begin
            checks++; errors++;
            $display("FAIL pop_empty2: fifo_rd=1, required 0 with FIFO empty");
         end else begin
            t = fq2.pop_front(); pops2++;
         end
      end
      while (pend1.size() != 0) fq1.push_back(pend1.pop_front());
      while (pend2.size() != 0) fq2.push_back(pend2.pop_front());
      fe1 <= (fq1.size() != 0);
      fe2 <= (fq2.size() != 0);
      if (fq1.size() != 0) fd1 <= fq1[0];
      if (fq2.size() != 0) fd2 <= fq2[0];
   end

   // monitor: compare each published frame against the scoreboard, police pop spacing
   logic prev_rd1 = 1'b0, prev_rd2 = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      #1;
      if (!rst) begin
         if (sv1) begin
            if (exp1.size() == 0) begin
               checks++; errors++;
               $display("FAIL valid1: sample_valid=1, required 0 (no frame due)");
            end else begin
               e = exp1.pop_front();
               check("out1", {24'h0, so1}, {16'h0, e.out});
               check("ur1", {31'h0, ur1}, {31'h0, e.ur});
               check("cnt1", {16'h0, uc1}, {16'h0, e.cnt});
            end
         end else if (ur1) check("ur_no_valid1", {31'h0, ur1}, 32'h0);
         if (sv2) begin
            if (exp2.size() == 0) begin
               checks++; errors++;
               $display("FAIL valid2: sample_valid=1, required 0 (no frame due)");
            end else begin
               e = exp2.pop_front();
               check("out2", {16'h0, so2}, {16'h0, e.out});
               check("ur2", {31'h0, ur2}, {31'h0, e.ur});
               check("cnt2", {16'h0, uc2}, {16'h0, e.cnt});
            end
         end else if (ur2) check("ur_no_valid2", {31'h0, ur2}, 32'h0);
         if (rd1) check("rd_gap1", {31'h0, prev_rd1}, 32'h0);
         if (rd2) check("rd_gap2", {31'h0, prev_rd2}, 32'h0);
         prev_rd1 = rd1;
         prev_rd2 = rd2;
      end
   end

   // Called on the negedge just before a period boundary: settle the previous period, offer new words.
   task automatic run_period(input logic [1:0] md, input bit mu,
                             input int n1, input logic [15:0] a1, input logic [15:0] b1,
                             input int n2, input logic [15:0] a2, input logic [15:0] b2, input logic [15:0] c2);
      exp_t e;
      logic [15:0] w0, w1;
      underrun_mute = mu;
      mode = md;
      if (pv1) begin
         if (pfull1) last1 = pframe1;
         else begin
            if (mu) last1 = 16'h0080;
            if (ucount1 != 16'hFFFF) ucount1++;
         end
         e.out = last1; e.ur = !pfull1; e.cnt = ucount1;
         exp1.push_back(e);
      end
      if (pv2) begin
         if (pfull2) last2 = pframe2;
         else begin
            if (mu) last2 = 16'h8080;
            if (ucount2 != 16'hFFFF) ucount2++;
         end
         e.out = last2; e.ur = !pfull2; e.cnt = ucount2;
         exp2.push_back(e);
      end
      for (int i = 0; i < n1; i++) begin
         w0 = (i == 0) ? a1 : b1;
         rq1.push_back(w0); pend1.push_back(w0);
      end
      for (int i = 0; i < n2; i++) begin
         w0 = (i == 0) ? a2 : ((i == 1) ? b2 : c2);
         rq2.push_back(w0); pend2.push_back(w0);
      end
      // the one-channel adapter takes one word if any is waiting
      pv1 = 1;
      pfull1 = (rq1.size() >= 1);
      if (pfull1) begin
         w0 = rq1.pop_front(); cons1++;
         pframe1 = {8'h00, conv(w0, md)};
      end
      // the two-channel adapter takes up to two; a short frame loses what it took
      pv2 = 1;
      pfull2 = (rq2.size() >= 2);
      if (pfull2) begin
         w0 = rq2.pop_front(); w1 = rq2.pop_front(); cons2 += 2;
         pframe2 = {conv(w1, md), conv(w0, md)};
      end else if (rq2.size() == 1) begin
         w0 = rq2.pop_front(); cons2++;
      end
   endtask

   initial begin
      rst = 1'b1; enable = 1'b0; mode = 2'd1; underrun_mute = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      check("rst_out1", {24'h0, so1}, 32'h80);
      check("rst_out2", {16'h0, so2}, 32'h8080);
      check("rst_valid", {30'h0, sv1, sv2}, 32'h0);
      check("rst_ur", {30'h0, ur1, ur2}, 32'h0);
      check("rst_cnt", {uc1, uc2}, 32'h0);
      check("rst_rd", {30'h0, rd1, rd2}, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      enable = 1'b1;
      repeat (DIV - 1) @(negedge clk);
      // directed periods; the first boundary is the exempt first tick
      run_period(2'd1, 1'b1, 1, 16'hABCD, 16'h0, 2, 16'h1100, 16'h2200, 16'h0);
      repeat (DIV) @(negedge clk);
      run_period(2'd0, 1'b1, 1, 16'hAAAA, 16'h0, 2, 16'hAAAA, 16'h5555, 16'h0);
      repeat (DIV) @(negedge clk);
      run_period(2'd2, 1'b1, 1, 16'h12C0, 16'h0, 2, 16'hFFF0, 16'h12C0, 16'h0);
      repeat (DIV) @(negedge clk);
      run_period(2'd2, 1'b1, 1, 16'hFFF0, 16'h0, 1, 16'h7777, 16'h0, 16'h0);
      repeat (DIV) @(negedge clk);
      run_period(2'd1, 1'b1, 0, 16'h0, 16'h0, 2, 16'h3300, 16'h4400, 16'h0);
      repeat (DIV) @(negedge clk);
      run_period(2'd1, 1'b1, 0, 16'h0, 16'h0, 0, 16'h0, 16'h0, 16'h0);
      repeat (DIV) @(negedge clk);
      run_period(2'd1, 1'b1, 0, 16'h0, 16'h0, 0, 16'h0, 16'h0, 16'h0);
      repeat (DIV) @(negedge clk);
      run_period(2'd1, 1'b1, 1, 16'hC300, 16'h0, 2, 16'h0100, 16'h0200, 16'h0);
      repeat (DIV) @(negedge clk);
      run_period(2'd1, 1'b0, 0, 16'h0, 16'h0, 0, 16'h0, 16'h0, 16'h0);
      repeat (DIV) @(negedge clk);
      run_period(2'd1, 1'b0, 0, 16'h0, 16'h0, 0, 16'h0, 16'h0, 16'h0);
      repeat (DIV) @(negedge clk);
      run_period(2'd1, 1'b0, 0, 16'h0, 16'h0, 0, 16'h0, 16'h0, 16'h0);
      repeat (DIV) @(negedge clk);
      // randomized periods
      for (int p = 0; p < 40; p++) begin
         run_period(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 2)), 16'($urandom), 16'($urandom),
                    int'($urandom_range(0, 3)), 16'($urandom), 16'($urandom), 16'($urandom));
         repeat (DIV) @(negedge clk);
      end
      // leave one adapter idle-fetching and the other mid-frame, then drop enable
      run_period(2'd1, 1'b1, 0, 16'h0, 16'h0, 1, 16'h5A00, 16'h0, 16'h0);
      repeat (3) @(negedge clk);
      enable = 1'b0;
      pend1.push_back(16'hDEAD);
      pend2.push_back(16'hBEEF);
      @(negedge clk);
      #1;
      check("dis_rd1", {31'h0, rd1}, 32'h0);
      check("dis_rd2", {31'h0, rd2}, 32'h0);
      repeat (DIV + 2) @(negedge clk);
      #1;
      check("hold_out1", {24'h0, so1}, {16'h0, last1});
      check("hold_out2", {16'h0, so2}, {16'h0, last2});
      check("frames_left1", exp1.size(), 0);
      check("frames_left2", exp2.size(), 0);
      check("pops1", pops1, cons1);
      check("pops2", pops2, cons2);
      // asynchronous reset mid-cycle
      #1;
      rst = 1'b1;
      #1;
      check("arst_out1", {24'h0, so1}, 32'h80);
      check("arst_out2", {16'h0, so2}, 32'h8080);
      check("arst_cnt", {uc1, uc2}, 32'h0);
      check("arst_flags", {28'h0, sv1, sv2, ur1, ur2}, 32'h0);
      check("arst_rd", {30'h0, rd1, rd2}, 32'h0);
      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
